// File: rtl/draw_rect_engine.sv
// Rectangle rasteriser: normalises and clips two corners, then scans the region
// row-major and emits one framebuffer write per cycle under a ready/valid handshake.
module draw_rect_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COORD_W  = 8,
    parameter int ADDR_W   = 15,
    parameter int COLOR_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    input  logic               mode,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               busy,
    output logic               finished
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] SW_BITS = 32'(SCREEN_W);

    state_t state;

    // Latched request
    logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
    logic [COLOR_W-1:0] lcolor;
    logic               lmode;

    // Normalised (unclipped) bounds, clipped far corner and scan position
    logic [COORD_W-1:0] nx0, nx1, ny0, ny1;
    logic [COORD_W-1:0] cx1, cy1;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [ADDR_W-1:0]  row_base;

    // Clamp a coordinate to the last visible index of an axis of size limit.
    function automatic logic [COORD_W-1:0] clip_hi(input logic [COORD_W-1:0] v, input int limit);
        if (int'(v) > limit - 1)
            return COORD_W'(limit - 1);
        else
            return v;
    endfunction

    // y * SCREEN_W as a sum of shifted copies of y over the set bits of SCREEN_W.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (SW_BITS[i])
                acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    function automatic logic on_outline(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] bx0,
        input logic [COORD_W-1:0] bx1,
        input logic [COORD_W-1:0] by0,
        input logic [COORD_W-1:0] by1
    );
        return (x == bx0) || (x == bx1) || (y == by0) || (y == by1);
    endfunction

    // SETUP-cycle combinational geometry, derived from the latched request
    logic [COORD_W-1:0] s_nx0, s_nx1, s_ny0, s_ny1;
    logic [COORD_W-1:0] s_cx1, s_cy1;
    logic               s_empty;
    logic [ADDR_W-1:0]  s_row_base;

    always_comb begin
        s_nx0      = (lx0 <= lx1) ? lx0 : lx1;
        s_nx1      = (lx0 <= lx1) ? lx1 : lx0;
        s_ny0      = (ly0 <= ly1) ? ly0 : ly1;
        s_ny1      = (ly0 <= ly1) ? ly1 : ly0;
        s_cx1      = clip_hi(s_nx1, SCREEN_W);
        s_cy1      = clip_hi(s_ny1, SCREEN_H);
        s_empty    = (int'(s_nx0) >= SCREEN_W) || (int'(s_ny0) >= SCREEN_H);
        s_row_base = row_offset(s_ny0);
    end

    // DRAW-cycle successor of the current candidate
    logic               at_eol, at_last, adv, next_we;
    logic [COORD_W-1:0] next_x, next_y;
    logic [ADDR_W-1:0]  next_base, next_addr;

    always_comb begin
        at_eol    = (cur_x == cx1);
        at_last   = at_eol && (cur_y == cy1);
        adv       = (state == DRAW) && (!mem_we || mem_ready);
        next_x    = at_eol ? nx0 : cur_x + 1'b1;
        next_y    = at_eol ? cur_y + 1'b1 : cur_y;
        next_base = at_eol ? row_base + ADDR_W'(SCREEN_W) : row_base;
        next_addr = at_eol ? next_base + ADDR_W'(nx0) : mem_addr + 1'b1;
        next_we   = !lmode || on_outline(next_x, next_y, nx0, nx1, ny0, ny1);
    end

    // Request capture and scan-position registers (no reset: qualified by state)
    always_ff @(posedge clk) begin
        if ((state == IDLE || state == DONE) && start) begin
            lx0    <= x0;
            ly0    <= y0;
            lx1    <= x1;
            ly1    <= y1;
            lcolor <= color;
            lmode  <= mode;
        end
        if (state == SETUP) begin
            nx0      <= s_nx0;
            nx1      <= s_nx1;
            ny0      <= s_ny0;
            ny1      <= s_ny1;
            cx1      <= s_cx1;
            cy1      <= s_cy1;
            cur_x    <= s_nx0;
            cur_y    <= s_ny0;
            row_base <= s_row_base;
        end else if (adv && !at_last) begin
            cur_x    <= next_x;
            cur_y    <= next_y;
            row_base <= next_base;
        end
    end

    // Control FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        finished <= 1'b0;
                    end
                end
                SETUP: begin
                    if (s_empty) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        state    <= DRAW;
                        mem_addr <= s_row_base + ADDR_W'(s_nx0);
                        mem_data <= lcolor;
                        // The first candidate is corner (nx0,ny0), drawn in both modes.
                        mem_we   <= 1'b1;
                    end
                end
                DRAW: begin
                    if (adv) begin
                        if (at_last) begin
                            state    <= DONE;
                            mem_we   <= 1'b0;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            mem_addr <= next_addr;
                            mem_we   <= next_we;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
